// File: rtl/viterbi_dispatcher.sv
// viterbi_dispatcher: pushes every frame to the symbol FIFO and steers flagged frames to a credited Viterbi unit.
// Define DISPATCH_STATS_EN to add per-unit saturating dispatch counters on dispatch_count.
module viterbi_dispatcher #(
  parameter int num_of_channels = 40,
  parameter int num_of_viterbis = 4,
  parameter int sym_width       = 3,
  parameter int vit_depth       = 2,
  parameter int guard           = 2,
  parameter int cnt_width       = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [num_of_channels-1:0][sym_width-1:0] in_syms,
  input  logic [num_of_channels-1:0]                in_flags,
  input  logic                                      in_valid,
  output logic [num_of_channels-1:0][sym_width-1:0] syms_out,
  output logic [num_of_viterbis-1:0]                tag_out,
  output logic                                      syms_push_n,
  input  logic                                      syms_full,
  output logic [num_of_channels-1:0][sym_width-1:0] vit_syms,
  output logic [num_of_viterbis-1:0]                vit_push_n,
  input  logic [num_of_viterbis-1:0]                corr_pop_n,
  output logic [cnt_width-1:0]                      drop_count,
  output logic                                      ovf_sticky
`ifdef DISPATCH_STATS_EN
  ,
  output logic [num_of_viterbis-1:0][cnt_width-1:0] dispatch_count
`endif
);

  localparam int PW = (num_of_viterbis > 1) ? $clog2(num_of_viterbis) : 1;
  localparam int CW = $clog2(vit_depth + 1);

  typedef enum logic {ChainIdle, ChainHeld} chain_e;

  logic [num_of_channels-1:0][sym_width-1:0] symsOut_q, symsOut_d;
  logic [num_of_channels-1:0][sym_width-1:0] vitSyms_q, vitSyms_d;
  logic [num_of_viterbis-1:0] tag_q, tag_d;
  logic                       symsPushN_q, symsPushN_d;
  logic [num_of_viterbis-1:0] vitPushN_q, vitPushN_d;
  logic [cnt_width-1:0]       dropCount_q, dropCount_d;
  logic                       ovf_q, ovf_d;
  logic [CW-1:0]              credit_q [num_of_viterbis];
  logic [CW-1:0]              credit_d [num_of_viterbis];
  logic [PW-1:0]              rrPtr_q, rrPtr_d;
  chain_e                     chain_q, chain_d;
  logic [PW-1:0]              chainIdx_q, chainIdx_d;
  logic [num_of_viterbis-1:0] dispatch;
  logic                       hit;
  logic [PW-1:0]              target;
  logic [PW-1:0]              cand;

  // Tag selection: chain wins over round-robin; credit checks use only registered counts.
  always_comb begin
    symsOut_d   = symsOut_q;
    vitSyms_d   = vitSyms_q;
    tag_d       = '0;
    symsPushN_d = 1'b1;
    vitPushN_d  = '1;
    dropCount_d = dropCount_q;
    ovf_d       = ovf_q;
    rrPtr_d     = rrPtr_q;
    chain_d     = chain_q;
    chainIdx_d  = chainIdx_q;
    dispatch    = '0;
    hit         = 1'b0;
    target      = chainIdx_q;
    cand        = '0;
    if (in_valid) begin
      chain_d = ChainIdle;
      if (syms_full) begin
        if (dropCount_q != '1) dropCount_d = dropCount_q + 1'b1;
      end else begin
        symsPushN_d = 1'b0;
        symsOut_d   = in_syms;
        if (chain_q == ChainHeld) begin
          hit = (credit_q[chainIdx_q] != '0);
        end else if (|in_flags) begin
          for (int k = num_of_viterbis - 1; k >= 0; k--) begin
            cand = PW'((int'(rrPtr_q) + k) % num_of_viterbis);
            if (credit_q[cand] != '0) begin
              hit    = 1'b1;
              target = cand;
            end
          end
          if (hit) rrPtr_d = PW'((int'(target) + 1) % num_of_viterbis);
        end
        if (hit) begin
          dispatch[target] = 1'b1;
          tag_d            = dispatch;
          vitPushN_d       = ~dispatch;
          vitSyms_d        = in_syms;
        end else if ((chain_q == ChainHeld) || (|in_flags)) begin
          ovf_d = 1'b1;
        end
        if (hit && (|in_flags[num_of_channels-1 -: guard])) begin
          chain_d    = ChainHeld;
          chainIdx_d = target;
        end
      end
    end
  end

  // Returns at full credit are dropped so the count can never exceed the unit FIFO depth.
  always_comb begin
    for (int i = 0; i < num_of_viterbis; i++) begin
      credit_d[i] = credit_q[i];
      if (dispatch[i] && !(!corr_pop_n[i] && (credit_q[i] != CW'(vit_depth))))
        credit_d[i] = credit_q[i] - 1'b1;
      else if (!dispatch[i] && !corr_pop_n[i] && (credit_q[i] != CW'(vit_depth)))
        credit_d[i] = credit_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      symsOut_q   <= '0;
      vitSyms_q   <= '0;
      tag_q       <= '0;
      symsPushN_q <= 1'b1;
      vitPushN_q  <= '1;
      dropCount_q <= '0;
      ovf_q       <= 1'b0;
      rrPtr_q     <= '0;
      chain_q     <= ChainIdle;
      chainIdx_q  <= '0;
      for (int i = 0; i < num_of_viterbis; i++) credit_q[i] <= CW'(vit_depth);
    end else begin
      symsOut_q   <= symsOut_d;
      vitSyms_q   <= vitSyms_d;
      tag_q       <= tag_d;
      symsPushN_q <= symsPushN_d;
      vitPushN_q  <= vitPushN_d;
      dropCount_q <= dropCount_d;
      ovf_q       <= ovf_d;
      rrPtr_q     <= rrPtr_d;
      chain_q     <= chain_d;
      chainIdx_q  <= chainIdx_d;
      for (int i = 0; i < num_of_viterbis; i++) credit_q[i] <= credit_d[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < num_of_viterbis; i++)
      assert (rst || corr_pop_n[i] || (credit_q[i] != CW'(vit_depth)))
        else $error("credit return on unit %0d with no outstanding dispatch", i);
  end

`ifdef DISPATCH_STATS_EN
  logic [num_of_viterbis-1:0][cnt_width-1:0] dispatchCount_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dispatchCount_q <= '0;
    end else begin
      for (int i = 0; i < num_of_viterbis; i++)
        if (dispatch[i] && (dispatchCount_q[i] != '1))
          dispatchCount_q[i] <= dispatchCount_q[i] + 1'b1;
    end
  end

  assign dispatch_count = dispatchCount_q;
`endif

  assign syms_out    = symsOut_q;
  assign vit_syms    = vitSyms_q;
  assign tag_out     = tag_q;
  assign syms_push_n = symsPushN_q;
  assign vit_push_n  = vitPushN_q;
  assign drop_count  = dropCount_q;
  assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_viterbi_dispatcher.sv
// tb_viterbi_dispatcher: scoreboard bench for viterbi_dispatcher; expected tags come from hand-derived tables.
// Builds with or without DISPATCH_STATS_EN.
module tb_viterbi_dispatcher;

  localparam int NCH  = 40;
  localparam int NV   = 4;
  localparam int SW   = 3;
  localparam int CNTW = 16;

  typedef logic [NCH-1:0][SW-1:0] frame_t;
  typedef struct {
    logic [NV-1:0] tag;
    frame_t        syms;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  frame_t         in_syms = '0;
  logic [NCH-1:0] in_flags = '0;
  logic           in_valid = 1'b0;
  frame_t         syms_out;
  logic [NV-1:0]  tag_out;
  logic           syms_push_n;
  logic           syms_full = 1'b0;
  frame_t         vit_syms;
  logic [NV-1:0]  vit_push_n;
  logic [NV-1:0]  corr_pop_n = '1;
  logic [CNTW-1:0] drop_count;
  logic           ovf_sticky;
`ifdef DISPATCH_STATS_EN
  logic [NV-1:0][CNTW-1:0] dispatch_count;
`endif

  exp_t expQ[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  viterbi_dispatcher dut (
    .clk         (clk),
    .rst         (rst),
    .in_syms     (in_syms),
    .in_flags    (in_flags),
    .in_valid    (in_valid),
    .syms_out    (syms_out),
    .tag_out     (tag_out),
    .syms_push_n (syms_push_n),
    .syms_full   (syms_full),
    .vit_syms    (vit_syms),
    .vit_push_n  (vit_push_n),
    .corr_pop_n  (corr_pop_n),
    .drop_count  (drop_count),
    .ovf_sticky  (ovf_sticky)
`ifdef DISPATCH_STATS_EN
    ,
    .dispatch_count (dispatch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic frame_t randFrame();
    frame_t r;
    for (int c = 0; c < NCH; c++) r[c] = SW'($urandom_range(7, 0));
    return r;
  endfunction

  function automatic logic [NCH-1:0] flagBit(input int b);
    logic [NCH-1:0] f;
    f = '0;
    if (b >= 0) f[b] = 1'b1;
    return f;
  endfunction

  // Drives one cycle of inputs and returns #1 after the edge that registers them.
  task automatic applyStimulus(input frame_t f, input logic [NCH-1:0] fl, input logic v,
                               input logic full, input logic [NV-1:0] pops);
    in_syms    = f;
    in_flags   = fl;
    in_valid   = v;
    syms_full  = full;
    corr_pop_n = pops;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_flags   = '0;
    syms_full  = 1'b0;
    corr_pop_n = '1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (syms_push_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_push_n got=%b exp=1", syms_push_n); end
    checks++; if (vit_push_n !== 4'hF) begin errors++; $display("[TB] FAIL reset_vit_push_n got=%b exp=1111", vit_push_n); end
    checks++; if (tag_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_tag got=%b exp=0000", tag_out); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop got=%0d exp=0", drop_count); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got=%b exp=0", ovf_sticky); end
    checks++; if (syms_out !== '0) begin errors++; $display("[TB] FAIL reset_syms_out got=%h exp=0", syms_out); end
    checks++; if (vit_syms !== '0) begin errors++; $display("[TB] FAIL reset_vit_syms got=%h exp=0", vit_syms); end
  endtask

  // Nine flagged frames with no pops: two rounds of round-robin, then credit exhaustion.
  task automatic test_credit_exhaust();
    logic [NV-1:0] tags [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    frame_t f;
    doReset();
    for (int k = 0; k < 9; k++) begin
      f = randFrame();
      expQ.push_back('{tag: tags[k], syms: f});
      applyStimulus(f, flagBit(5), 1'b1, 1'b0, 4'hF);
      e = expQ.pop_front();
      checks++; if (syms_push_n !== 1'b0) begin errors++; $display("[TB] FAIL rr_push_n k=%0d got=%b exp=0", k, syms_push_n); end
      checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL rr_tag k=%0d got=%b exp=%b", k, tag_out, e.tag); end
      checks++; if (vit_push_n !== ~e.tag) begin errors++; $display("[TB] FAIL rr_vit_push_n k=%0d got=%b exp=%b", k, vit_push_n, ~e.tag); end
      checks++; if (syms_out !== e.syms) begin errors++; $display("[TB] FAIL rr_syms_out k=%0d got=%h exp=%h", k, syms_out, e.syms); end
      if (e.tag != '0) begin
        checks++; if (vit_syms !== e.syms) begin errors++; $display("[TB] FAIL rr_vit_syms k=%0d got=%h exp=%h", k, vit_syms, e.syms); end
      end
      if (k == 7) begin
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("[TB] FAIL rr_ovf_early got=%b exp=0", ovf_sticky); end
      end
    end
    applyStimulus(randFrame(), '0, 1'b0, 1'b0, 4'hF);
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("[TB] FAIL rr_ovf got=%b exp=1", ovf_sticky); end
    checks++; if (syms_push_n !== 1'b1) begin errors++; $display("[TB] FAIL rr_idle_push got=%b exp=1", syms_push_n); end
  endtask

  // Guard-channel flags chain the next frame to the same unit; an idle cycle keeps the chain.
  task automatic test_chain();
    int            fb [8]   = '{5, 5, 39, -1, -1, 38, -1, -1};
    bit            vld [8]  = '{1, 1, 1, 1, 1, 1, 0, 1};
    logic [NV-1:0] tags [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100,
                                4'b0000, 4'b1000, 4'b0000, 4'b1000};
    frame_t f;
    doReset();
    for (int k = 0; k < 8; k++) begin
      f = randFrame();
      if (vld[k]) expQ.push_back('{tag: tags[k], syms: f});
      applyStimulus(f, flagBit(fb[k]), vld[k], 1'b0, 4'hF);
      if (vld[k]) begin
        e = expQ.pop_front();
        checks++; if (syms_push_n !== 1'b0) begin errors++; $display("[TB] FAIL chain_push_n k=%0d got=%b exp=0", k, syms_push_n); end
        checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL chain_tag k=%0d got=%b exp=%b", k, tag_out, e.tag); end
        checks++; if (vit_push_n !== ~e.tag) begin errors++; $display("[TB] FAIL chain_vit_push_n k=%0d got=%b exp=%b", k, vit_push_n, ~e.tag); end
        checks++; if (syms_out !== e.syms) begin errors++; $display("[TB] FAIL chain_syms_out k=%0d got=%h exp=%h", k, syms_out, e.syms); end
      end else begin
        checks++; if (syms_push_n !== 1'b1 || vit_push_n !== 4'hF) begin
          errors++; $display("[TB] FAIL chain_idle k=%0d got=%b/%b exp=1/1111", k, syms_push_n, vit_push_n);
        end
      end
    end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("[TB] FAIL chain_ovf got=%b exp=0", ovf_sticky); end
  endtask

  // Drops on a full FIFO count up and break the chain started before them.
  task automatic test_drop();
    frame_t f;
    doReset();
    f = randFrame();
    expQ.push_back('{tag: 4'b0001, syms: f});
    applyStimulus(f, flagBit(39), 1'b1, 1'b0, 4'hF);
    e = expQ.pop_front();
    checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL drop_first_tag got=%b exp=%b", tag_out, e.tag); end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(randFrame(), flagBit(39), 1'b1, 1'b1, 4'hF);
      checks++; if (syms_push_n !== 1'b1 || vit_push_n !== 4'hF) begin
        errors++; $display("[TB] FAIL drop_nopush k=%0d got=%b/%b exp=1/1111", k, syms_push_n, vit_push_n);
      end
    end
    checks++; if (drop_count !== 16'd3) begin errors++; $display("[TB] FAIL drop_count got=%0d exp=3", drop_count); end
    f = randFrame();
    expQ.push_back('{tag: 4'b0010, syms: f});
    applyStimulus(f, flagBit(5), 1'b1, 1'b0, 4'hF);
    e = expQ.pop_front();
    checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL drop_unchained_tag got=%b exp=%b", tag_out, e.tag); end
    checks++; if (syms_out !== e.syms) begin errors++; $display("[TB] FAIL drop_syms_out got=%h exp=%h", syms_out, e.syms); end
  endtask

  // A return on the same cycle as the scan does not make a unit eligible until the next cycle.
  task automatic test_back_to_back();
    frame_t f;
    doReset();
    for (int k = 0; k < 8; k++) applyStimulus(randFrame(), flagBit(5), 1'b1, 1'b0, 4'hF);
    applyStimulus(randFrame(), '0, 1'b0, 1'b0, 4'b1101);
    f = randFrame();
    expQ.push_back('{tag: 4'b0010, syms: f});
    applyStimulus(f, flagBit(5), 1'b1, 1'b0, 4'b1110);
    e = expQ.pop_front();
    checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL same_cycle_skip got=%b exp=%b", tag_out, e.tag); end
    checks++; if (vit_push_n !== ~e.tag) begin errors++; $display("[TB] FAIL same_cycle_vpn got=%b exp=%b", vit_push_n, ~e.tag); end
    f = randFrame();
    expQ.push_back('{tag: 4'b0001, syms: f});
    applyStimulus(f, flagBit(5), 1'b1, 1'b0, 4'hF);
    e = expQ.pop_front();
    checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL returned_unit got=%b exp=%b", tag_out, e.tag); end
    checks++; if (vit_syms !== e.syms) begin errors++; $display("[TB] FAIL returned_vit_syms got=%h exp=%h", vit_syms, e.syms); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("[TB] FAIL returned_ovf got=%b exp=0", ovf_sticky); end
  endtask

  // Reset in the middle of a chained stream wipes outputs, counters and the chain.
  task automatic test_reset_midstream();
    frame_t f;
    doReset();
    applyStimulus(randFrame(), '0, 1'b1, 1'b1, 4'hF);
    applyStimulus(randFrame(), flagBit(39), 1'b1, 1'b0, 4'hF);
    checks++; if (tag_out !== 4'b0001) begin errors++; $display("[TB] FAIL mid_pre_tag got=%b exp=0001", tag_out); end
    rst = 1'b1;
    applyStimulus(randFrame(), flagBit(39), 1'b1, 1'b0, 4'hF);
    rst = 1'b0;
    checks++; if (syms_push_n !== 1'b1 || vit_push_n !== 4'hF || tag_out !== 4'h0) begin
      errors++; $display("[TB] FAIL mid_rst_ctrl got=%b/%b/%b exp=1/1111/0000", syms_push_n, vit_push_n, tag_out);
    end
    checks++; if (syms_out !== '0 || vit_syms !== '0) begin errors++; $display("[TB] FAIL mid_rst_syms got=%h/%h exp=0/0", syms_out, vit_syms); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_rst_drop got=%0d exp=0", drop_count); end
`ifdef DISPATCH_STATS_EN
    checks++; if (dispatch_count !== '0) begin errors++; $display("[TB] FAIL mid_rst_stats got=%h exp=0", dispatch_count); end
`endif
    f = randFrame();
    expQ.push_back('{tag: 4'b0000, syms: f});
    applyStimulus(f, '0, 1'b1, 1'b0, 4'hF);
    e = expQ.pop_front();
    checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL mid_chain_cleared got=%b exp=%b", tag_out, e.tag); end
  endtask

`ifdef DISPATCH_STATS_EN
  // One dispatch to unit 0, then five to unit 1 held by the chain with credit returned each cycle.
  task automatic test_stats();
    logic [NV-1:0] tags [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    frame_t f;
    doReset();
    for (int k = 0; k < 6; k++) begin
      f = randFrame();
      expQ.push_back('{tag: tags[k], syms: f});
      applyStimulus(f, flagBit(k == 0 ? 5 : 39), 1'b1, 1'b0, (k >= 2) ? 4'b1101 : 4'b1111);
      e = expQ.pop_front();
      checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL stats_tag k=%0d got=%b exp=%b", k, tag_out, e.tag); end
    end
    applyStimulus(randFrame(), '0, 1'b0, 1'b0, 4'hF);
    checks++; if (dispatch_count[0] !== 16'd1) begin errors++; $display("[TB] FAIL stats_u0 got=%0d exp=1", dispatch_count[0]); end
    checks++; if (dispatch_count[1] !== 16'd5) begin errors++; $display("[TB] FAIL stats_u1 got=%0d exp=5", dispatch_count[1]); end
    checks++; if (dispatch_count[2] !== 16'd0 || dispatch_count[3] !== 16'd0) begin
      errors++; $display("[TB] FAIL stats_u23 got=%0d/%0d exp=0/0", dispatch_count[2], dispatch_count[3]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_credit_exhaust();
    test_chain();
    test_drop();
    test_back_to_back();
    test_reset_midstream();
`ifdef DISPATCH_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
